// File: rtl/block_nest_checker_if.sv
// Character-stream bus of the begin/end nesting checker: one byte per
// accepted cycle in, balance/depth/error status out.
interface block_nest_checker_if #(
    parameter int DEPTH_W = 8
);
    logic                      in_valid;
    logic [7:0]                in;
    logic                      result;
    logic signed [DEPTH_W-1:0] depth;
    logic                      err_underflow;
    logic                      err_overflow;

    modport master (
        output in_valid, in,
        input  result, depth, err_underflow, err_overflow
    );

    modport slave (
        input  in_valid, in,
        output result, depth, err_underflow, err_overflow
    );
endinterface

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker. Words are runs of non-delimiter
// characters; whole-word, case-insensitive "begin" and "end" move a signed
// depth counter. A keyword's effect is applied tentatively on its last
// letter and committed (or undone) by the next character.
module block_nest_checker #(
    parameter int DEPTH_W   = 8,
    parameter int STRICT    = 1,
    parameter int ALT_DELIM = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    block_nest_checker_if.slave  bus
);
    localparam logic signed [DEPTH_W-1:0] MAXV = {1'b0, {(DEPTH_W-1){1'b1}}};
    localparam logic signed [DEPTH_W-1:0] MINV = {1'b1, {(DEPTH_W-1){1'b0}}};
    localparam logic signed [DEPTH_W-1:0] ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        IDLE, B1, B2, B3, B4, BN, E1, E2, ED, SKIP, DEAD
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DEPTH_W-1:0] depth_q, depth_d;
    logic                      eu_q, eu_d;
    logic                      eo_q, eo_d;
    // "begin" seen at MAX: overflow pending until the word is committed
    logic                      pend_q, pend_d;
    // "end" seen at MIN: decrement was suppressed, so undo must not increment
    logic                      sat_q, sat_d;

    logic [7:0] lc;
    logic       delim;

    assign lc    = (bus.in >= 8'h41 && bus.in <= 8'h5A) ? (bus.in | 8'h20) : bus.in;
    assign delim = (bus.in == 8'h20) ||
                   ((ALT_DELIM != 0) && (bus.in == 8'h09 || bus.in == 8'h0A || bus.in == 8'h0D));

    // Next-state: word recognition plus tentative/commit/undo of depth effects
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        eu_d    = eu_q;
        eo_d    = eo_q;
        pend_d  = pend_q;
        sat_d   = sat_q;
        if (bus.in_valid) begin
            case (state_q)
                IDLE: begin
                    if (delim)              state_d = IDLE;
                    else if (lc == 8'h62)   state_d = B1;
                    else if (lc == 8'h65)   state_d = E1;
                    else                    state_d = SKIP;
                end
                B1: state_d = delim ? IDLE : (lc == 8'h65) ? B2 : SKIP;
                B2: state_d = delim ? IDLE : (lc == 8'h67) ? B3 : SKIP;
                B3: state_d = delim ? IDLE : (lc == 8'h69) ? B4 : SKIP;
                B4: begin
                    if (delim) state_d = IDLE;
                    else if (lc == 8'h6E) begin
                        state_d = BN;
                        if (depth_q != MAXV) depth_d = depth_q + ONE;
                        else                 pend_d  = 1'b1;
                    end else state_d = SKIP;
                end
                BN: begin
                    if (delim) begin
                        state_d = IDLE;
                        if (pend_q) begin
                            eo_d   = 1'b1;
                            pend_d = 1'b0;
                        end
                    end else begin
                        state_d = SKIP;
                        if (pend_q) pend_d  = 1'b0;
                        else        depth_d = depth_q - ONE;
                    end
                end
                E1: state_d = delim ? IDLE : (lc == 8'h6E) ? E2 : SKIP;
                E2: begin
                    if (delim) state_d = IDLE;
                    else if (lc == 8'h64) begin
                        state_d = ED;
                        if (depth_q != MINV) depth_d = depth_q - ONE;
                        else                 sat_d   = 1'b1;
                    end else state_d = SKIP;
                end
                ED: begin
                    sat_d = 1'b0;
                    if (delim) begin
                        if ((STRICT != 0) && depth_q[DEPTH_W-1]) begin
                            eu_d    = 1'b1;
                            state_d = DEAD;
                        end else state_d = IDLE;
                    end else begin
                        state_d = SKIP;
                        if (!sat_q) depth_d = depth_q + ONE;
                    end
                end
                SKIP:    state_d = delim ? IDLE : SKIP;
                DEAD:    state_d = DEAD;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            depth_q <= '0;
            eu_q    <= 1'b0;
            eo_q    <= 1'b0;
            pend_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            eu_q    <= eu_d;
            eo_q    <= eo_d;
            pend_q  <= pend_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.depth         = depth_q;
    assign bus.err_underflow = eu_q;
    assign bus.err_overflow  = eo_q;
    assign bus.result        = (depth_q == '0) && !eu_q && !eo_q && !pend_q;
endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: five parameter variants share one character
// stream and are each compared every cycle against a word-level model.
module tb_block_nest_checker;
    localparam int NDUT = 5;

    logic       clk = 1'b0;
    logic       tb_rst = 1'b0;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_in = 8'h00;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // variants: a=(8,strict,space) b=(8,lax,space) c=(3,strict,space) d=(8,strict,alt) e=(3,lax,space)
    int P_DW  [NDUT] = '{8, 8, 3, 8, 3};
    int P_STR [NDUT] = '{1, 0, 1, 1, 0};
    int P_ALT [NDUT] = '{0, 0, 0, 1, 0};

    block_nest_checker_if #(.DEPTH_W(8)) ifa ();
    block_nest_checker_if #(.DEPTH_W(8)) ifb ();
    block_nest_checker_if #(.DEPTH_W(3)) ifc ();
    block_nest_checker_if #(.DEPTH_W(8)) ifd ();
    block_nest_checker_if #(.DEPTH_W(3)) ife ();

    assign ifa.in_valid = tb_valid; assign ifa.in = tb_in;
    assign ifb.in_valid = tb_valid; assign ifb.in = tb_in;
    assign ifc.in_valid = tb_valid; assign ifc.in = tb_in;
    assign ifd.in_valid = tb_valid; assign ifd.in = tb_in;
    assign ife.in_valid = tb_valid; assign ife.in = tb_in;

    block_nest_checker #(.DEPTH_W(8), .STRICT(1), .ALT_DELIM(0)) dut_a (.clk(clk), .reset(tb_rst), .bus(ifa.slave));
    block_nest_checker #(.DEPTH_W(8), .STRICT(0), .ALT_DELIM(0)) dut_b (.clk(clk), .reset(tb_rst), .bus(ifb.slave));
    block_nest_checker #(.DEPTH_W(3), .STRICT(1), .ALT_DELIM(0)) dut_c (.clk(clk), .reset(tb_rst), .bus(ifc.slave));
    block_nest_checker #(.DEPTH_W(8), .STRICT(1), .ALT_DELIM(1)) dut_d (.clk(clk), .reset(tb_rst), .bus(ifd.slave));
    block_nest_checker #(.DEPTH_W(3), .STRICT(0), .ALT_DELIM(0)) dut_e (.clk(clk), .reset(tb_rst), .bus(ife.slave));

    // ---------------- reference model: committed depth + current word text
    int          m_cd [NDUT];
    bit          m_eu [NDUT];
    bit          m_eo [NDUT];
    bit          m_dead [NDUT];
    logic [47:0] m_wv [NDUT];
    int          m_wl [NDUT];

    function automatic int maxv(int k); return (1 << (P_DW[k] - 1)) - 1; endfunction
    function automatic int minv(int k); return -(1 << (P_DW[k] - 1)); endfunction
    function automatic bit is_begin(int k); return m_wl[k] == 5 && m_wv[k][39:0] == "begin"; endfunction
    function automatic bit is_end(int k);   return m_wl[k] == 3 && m_wv[k][23:0] == "end";   endfunction

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_cd[k] = 0; m_eu[k] = 0; m_eo[k] = 0; m_dead[k] = 0;
            m_wv[k] = '0; m_wl[k] = 0;
        end
    endfunction

    function automatic void model_acc(int k, logic [7:0] c);
        logic [7:0] lc;
        bit dl;
        int nd;
        if (m_dead[k]) return;
        lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
        dl = (c == " ") || (P_ALT[k] != 0 && (c == 8'h09 || c == 8'h0A || c == 8'h0D));
        if (dl) begin
            if (is_begin(k)) begin
                if (m_cd[k] < maxv(k)) m_cd[k]++;
                else                   m_eo[k] = 1;
            end else if (is_end(k)) begin
                nd = (m_cd[k] > minv(k)) ? m_cd[k] - 1 : m_cd[k];
                if (P_STR[k] != 0 && nd < 0) begin
                    m_eu[k] = 1; m_dead[k] = 1;
                end
                m_cd[k] = nd;
            end
            m_wv[k] = '0; m_wl[k] = 0;
        end else if (m_wl[k] < 6) begin
            m_wv[k] = {m_wv[k][39:0], lc};
            m_wl[k]++;
        end
    endfunction

    // expected {result, err_underflow, err_overflow, depth[7:0]}
    function automatic logic [10:0] exp_vec(int k);
        int d;
        bit pend;
        d = m_cd[k];
        pend = 0;
        if (!m_dead[k]) begin
            if (is_begin(k)) begin
                if (m_cd[k] < maxv(k)) d = m_cd[k] + 1;
                else                   pend = 1;
            end else if (is_end(k) && m_cd[k] > minv(k)) d = m_cd[k] - 1;
        end
        return {(d == 0) && !m_eu[k] && !m_eo[k] && !pend, m_eu[k], m_eo[k], d[7:0]};
    endfunction

    function automatic logic [10:0] obs_vec(int k);
        int d;
        logic r, u, o;
        case (k)
            0: begin d = ifa.depth; r = ifa.result; u = ifa.err_underflow; o = ifa.err_overflow; end
            1: begin d = ifb.depth; r = ifb.result; u = ifb.err_underflow; o = ifb.err_overflow; end
            2: begin d = ifc.depth; r = ifc.result; u = ifc.err_underflow; o = ifc.err_overflow; end
            3: begin d = ifd.depth; r = ifd.result; u = ifd.err_underflow; o = ifd.err_overflow; end
            default: begin d = ife.depth; r = ife.result; u = ife.err_underflow; o = ife.err_overflow; end
        endcase
        return {r, u, o, d[7:0]};
    endfunction

    task automatic send(input logic [7:0] c, input logic v);
        tb_in = c;
        tb_valid = v;
        @(posedge clk);
        #1;
        if (!tb_rst) model_reset();
        else if (v) for (int k = 0; k < NDUT; k++) model_acc(k, c);
    endtask

    // ---------------- tests
    task automatic test_reset();
        tb_rst = 1'b0;
        send("b", 1'b1);
        send("e", 1'b1);
        tb_rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            nvec++;
            if (obs_vec(k) !== 11'h400) begin
                nerr++;
                $display("FAIL reset dut%0d got=%h want=%h", k, obs_vec(k), 11'h400);
            end
        end
    endtask

    task automatic test_basic();
        string s = "BeGiN end ";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 1'b1);
            for (int k = 0; k < NDUT; k++) begin
                nvec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    nerr++;
                    $display("FAIL basic dut%0d ch%0d got=%h want=%h", k, i, obs_vec(k), exp_vec(k));
                end
            end
            if (i == 4) begin
                nvec++;
                if (ifa.depth !== 8'sd1) begin
                    nerr++;
                    $display("FAIL basic_depth1 got=%0d want=1", ifa.depth);
                end
            end
        end
        nvec++;
        if ({ifa.result, ifa.depth} !== {1'b1, 8'sd0}) begin
            nerr++;
            $display("FAIL basic_end got=%b/%0d want=1/0", ifa.result, ifa.depth);
        end
    endtask

    task automatic test_underflow();
        string s = "end begin ";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 1'b1);
            for (int k = 0; k < NDUT; k++) begin
                nvec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    nerr++;
                    $display("FAIL underflow dut%0d ch%0d got=%h want=%h", k, i, obs_vec(k), exp_vec(k));
                end
            end
        end
        nvec++;
        if ({ifa.err_underflow, ifa.result, ifa.depth} !== {1'b1, 1'b0, -8'sd1}) begin
            nerr++;
            $display("FAIL underflow_strict got=%b%b/%0d want=10/-1", ifa.err_underflow, ifa.result, ifa.depth);
        end
        nvec++;
        if ({ifb.err_underflow, ifb.result, ifb.depth} !== {1'b0, 1'b1, 8'sd0}) begin
            nerr++;
            $display("FAIL underflow_lax got=%b%b/%0d want=01/0", ifb.err_underflow, ifb.result, ifb.depth);
        end
        tb_rst = 1'b0;
        send(" ", 1'b0);
        tb_rst = 1'b1;
        nvec++;
        if ({ifa.err_underflow, ifa.result, ifa.depth} !== {1'b0, 1'b1, 8'sd0}) begin
            nerr++;
            $display("FAIL underflow_reset got=%b%b/%0d want=01/0", ifa.err_underflow, ifa.result, ifa.depth);
        end
    endtask

    task automatic test_partial();
        string s = "beginx endy bEGIn endbegin xend ";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 1'b1);
            for (int k = 0; k < NDUT; k++) begin
                nvec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    nerr++;
                    $display("FAIL partial dut%0d ch%0d got=%h want=%h", k, i, obs_vec(k), exp_vec(k));
                end
            end
        end
        nvec++;
        if (ifb.depth !== 8'sd1) begin
            nerr++;
            $display("FAIL partial_depth got=%0d want=1", ifb.depth);
        end
    endtask

    task automatic test_overflow();
        string s = "begin begin begin begin end end end ";
        tb_rst = 1'b0;
        send(" ", 1'b0);
        tb_rst = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 1'b1);
            for (int k = 0; k < NDUT; k++) begin
                nvec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    nerr++;
                    $display("FAIL overflow dut%0d ch%0d got=%h want=%h", k, i, obs_vec(k), exp_vec(k));
                end
            end
            if (i == 22) begin
                nvec++;
                if ({ifc.result, ifc.err_overflow, ifc.depth} !== {1'b0, 1'b0, 3'sd3}) begin
                    nerr++;
                    $display("FAIL overflow_pend got=%b%b/%0d want=00/3", ifc.result, ifc.err_overflow, ifc.depth);
                end
            end
        end
        nvec++;
        if ({ifc.result, ifc.err_overflow, ifc.depth} !== {1'b0, 1'b1, 3'sd0}) begin
            nerr++;
            $display("FAIL overflow_sticky got=%b%b/%0d want=01/0", ifc.result, ifc.err_overflow, ifc.depth);
        end
    endtask

    task automatic test_alt_delim();
        string s = "begin\tend\n";
        for (int pass = 0; pass < 2; pass++) begin
            tb_rst = 1'b0;
            send(" ", 1'b0);
            tb_rst = 1'b1;
            for (int i = 0; i < s.len(); i++) begin
                if (pass == 1) send(8'($urandom_range(8, 122)), 1'b0);
                send(s[i], 1'b1);
                for (int k = 0; k < NDUT; k++) begin
                    nvec++;
                    if (obs_vec(k) !== exp_vec(k)) begin
                        nerr++;
                        $display("FAIL alt dut%0d pass%0d ch%0d got=%h want=%h", k, pass, i, obs_vec(k), exp_vec(k));
                    end
                end
            end
            nvec++;
            if ({ifd.result, ifd.depth} !== {1'b1, 8'sd0}) begin
                nerr++;
                $display("FAIL alt_result pass%0d got=%b/%0d want=1/0", pass, ifd.result, ifd.depth);
            end
        end
    endtask

    task automatic test_random();
        string toks [12] = '{"begin", "end", "BEGIN", "End", "bEgIn", "beginx",
                             "xend", "bed", "e", "begi", "en", "zq"};
        logic [7:0] dls [5] = '{8'h20, 8'h09, 8'h0A, 8'h0D, 8'h20};
        logic [7:0] qc[$];
        bit qv[$];
        bit qr[$];
        string t;
        for (int n = 0; n < 350; n++) begin
            t = toks[$urandom_range(0, 11)];
            for (int i = 0; i < t.len(); i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    qc.push_back(8'($urandom)); qv.push_back(1'b0); qr.push_back(1'b1);
                end
                qc.push_back(t[i]); qv.push_back(1'b1);
                qr.push_back($urandom_range(0, 150) != 0);
            end
            for (int j = $urandom_range(0, 2); j >= 0; j--) begin
                qc.push_back(dls[$urandom_range(0, 4)]); qv.push_back(1'b1); qr.push_back(1'b1);
            end
        end
        for (int i = 0; i < qc.size(); i++) begin
            tb_rst = qr[i];
            send(qc[i], qv[i]);
            tb_rst = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                nvec++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    nerr++;
                    $display("FAIL random dut%0d step%0d got=%h want=%h", k, i, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_underflow();
        test_partial();
        test_overflow();
        test_alt_delim();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
